// File: rtl/bcd_year_to_bin.sv
// ----------------------------------------------------------------------------
// bcd_year_to_bin
//
// Converts a four-digit BCD year (thousands..ones) into a 12-bit binary year.
// One digit is folded into a 14-bit accumulator per clock (acc*10 + digit,
// built from shifts and adds). A final check cycle either publishes the
// result or flags it as rejected.
//
// Ports:
//   clk     in   1   system clock, rising edge
//   rst     in   1   asynchronous, active-high reset
//   start   in   1   request a conversion (honoured only when idle)
//   d_thou  in   4   BCD thousands digit, sampled with start
//   d_hund  in   4   BCD hundreds digit, sampled with start
//   d_tens  in   4   BCD tens digit, sampled with start
//   d_ones  in   4   BCD ones digit, sampled with start
//   busy    out  1   conversion in progress
//   done    out  1   one-cycle pulse, year/err freshly updated
//   year    out  12  binary year, held until the next done
//   err     out  1   result rejected, held until the next done
//
// Configuration macro:
//   RANGE_CHECK_EN  when defined, years outside 2025..3025 are also rejected.
// ----------------------------------------------------------------------------
module bcd_year_to_bin (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  d_thou,
    input  logic [3:0]  d_hund,
    input  logic [3:0]  d_tens,
    input  logic [3:0]  d_ones,
    output logic        busy,
    output logic        done,
    output logic [11:0] year,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [15:0]  digs_q, digs_d;
    logic [13:0]  acc_q, acc_d;
    logic [1:0]   step_q, step_d;
    logic         derr_q, derr_d;
    logic         busy_d, done_d, err_d;
    logic [11:0]  year_d;
    logic [3:0]   cur_digit;

    // acc*10 + digit without a multiplier: (acc<<3) + (acc<<1) + digit.
    // Only digit values above 9 can push this past 14 bits, and those
    // conversions are rejected through the digit-error flag anyway.
    function automatic logic [13:0] mac10(input logic [13:0] acc,
                                          input logic [3:0]  digit);
        return (acc << 3) + (acc << 1) + {10'd0, digit};
    endfunction

    function automatic logic reject(input logic [13:0] acc,
                                    input logic        digit_err);
        logic r;
        r = digit_err || (acc > 14'd4095);
`ifdef RANGE_CHECK_EN
        r = r || (acc < 14'd2025) || (acc > 14'd3025);
`endif
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        digs_d    = digs_q;
        acc_d     = acc_q;
        step_d    = step_q;
        derr_d    = derr_q;
        busy_d    = busy;
        done_d    = 1'b0;
        year_d    = year;
        err_d     = err;
        cur_digit = 4'd0;

        // Digits are consumed most-significant first
        case (step_q)
            2'd0:    cur_digit = digs_q[15:12];
            2'd1:    cur_digit = digs_q[11:8];
            2'd2:    cur_digit = digs_q[7:4];
            default: cur_digit = digs_q[3:0];
        endcase

        case (state_q)
            IDLE: begin
                if (start) begin
                    digs_d  = {d_thou, d_hund, d_tens, d_ones};
                    acc_d   = 14'd0;
                    derr_d  = 1'b0;
                    step_d  = 2'd0;
                    busy_d  = 1'b1;
                    state_d = CONV;
                end
            end
            CONV: begin
                acc_d  = mac10(acc_q, cur_digit);
                if (cur_digit > 4'd9) begin
                    derr_d = 1'b1;
                end
                step_d = step_q + 2'd1;
                if (step_q == 2'd3) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (reject(acc_q, derr_q)) begin
                    year_d = 12'd0;
                    err_d  = 1'b1;
                end else begin
                    year_d = acc_q[11:0];
                    err_d  = 1'b0;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            digs_q  <= 16'd0;
            acc_q   <= 14'd0;
            step_q  <= 2'd0;
            derr_q  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            year    <= 12'd0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            digs_q  <= digs_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
            derr_q  <= derr_d;
            busy    <= busy_d;
            done    <= done_d;
            year    <= year_d;
            err     <= err_d;
        end
    end

endmodule

// File: tb/tb_bcd_year_to_bin.sv
// ----------------------------------------------------------------------------
// tb_bcd_year_to_bin
//
// Directed bench for bcd_year_to_bin: reset state, conversion timing,
// accept/reject results, ignored mid-conversion start, back-to-back start in
// the done cycle, and reset abort. Outputs are sampled on the falling edge.
// Expectations follow RANGE_CHECK_EN when that macro is defined.
// ----------------------------------------------------------------------------
module tb_bcd_year_to_bin;

`ifdef RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  d_thou, d_hund, d_tens, d_ones;
    logic        busy, done, err;
    logic [11:0] year;

    int tests;
    int fails;

    bcd_year_to_bin dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .d_thou (d_thou),
        .d_hund (d_hund),
        .d_tens (d_tens),
        .d_ones (d_ones),
        .busy   (busy),
        .done   (done),
        .year   (year),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_digits(input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] c, input logic [3:0] e);
        d_thou = a;
        d_hund = b;
        d_tens = c;
        d_ones = e;
    endtask

    // Called at a falling edge with the DUT idle. Ends at a falling edge
    // one cycle after the done pulse.
    task automatic do_conv(input string tag, input logic [3:0] a,
                           input logic [3:0] b, input logic [3:0] c,
                           input logic [3:0] e, input logic [11:0] ey,
                           input logic ee);
        set_digits(a, b, c, e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, ".busy_e0"}, {31'd0, busy}, 32'd1);
        chk({tag, ".done_e0"}, {31'd0, done}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk({tag, ".busy_mid"}, {31'd0, busy}, 32'd1);
            chk({tag, ".done_mid"}, {31'd0, done}, 32'd0);
        end
        @(negedge clk);
        chk({tag, ".done"}, {31'd0, done}, 32'd1);
        chk({tag, ".busy_end"}, {31'd0, busy}, 32'd0);
        chk({tag, ".year"}, {20'd0, year}, {20'd0, ey});
        chk({tag, ".err"}, {31'd0, err}, {31'd0, ee});
        @(negedge clk);
        chk({tag, ".done_once"}, {31'd0, done}, 32'd0);
        chk({tag, ".year_hold"}, {20'd0, year}, {20'd0, ey});
        chk({tag, ".err_hold"}, {31'd0, err}, {31'd0, ee});
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        start = 1'b0;
        set_digits(4'd0, 4'd0, 4'd0, 4'd0);

        // Reset state, and start ignored while rst is high at an edge
        #1;
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.done", {31'd0, done}, 32'd0);
        chk("rst.year", {20'd0, year}, 32'd0);
        chk("rst.err",  {31'd0, err},  32'd0);
        set_digits(4'd2, 4'd0, 4'd2, 4'd5);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        chk("rst.start_ignored", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("rst.still_idle", {31'd0, busy}, 32'd0);

        // Basic conversions and boundaries
        do_conv("y2025", 4'd2, 4'd0, 4'd2, 4'd5, 12'h7E9, 1'b0);
        do_conv("y3025", 4'd3, 4'd0, 4'd2, 4'd5, 12'hBD1, 1'b0);
        do_conv("y2024", 4'd2, 4'd0, 4'd2, 4'd4,
                RC ? 12'h000 : 12'h7E8, RC);
        do_conv("y20A5", 4'd2, 4'd0, 4'hA, 4'd5, 12'h000, 1'b1);
        do_conv("y9999", 4'd9, 4'd9, 4'd9, 4'd9, 12'h000, 1'b1);
        do_conv("y0000", 4'd0, 4'd0, 4'd0, 4'd0, 12'h000, RC);
        do_conv("y4095", 4'd4, 4'd0, 4'd9, 4'd5,
                RC ? 12'h000 : 12'hFFF, RC);
        do_conv("y4096", 4'd4, 4'd0, 4'd9, 4'd6, 12'h000, 1'b1);
        do_conv("yF000", 4'hF, 4'd0, 4'd0, 4'd0, 12'h000, 1'b1);

        // Second start at E2 with other digits must be ignored
        set_digits(4'd3, 4'd0, 4'd2, 4'd5);
        start = 1'b1;
        @(negedge clk);               // after E0
        start = 1'b0;
        @(negedge clk);               // after E1
        set_digits(4'd2, 4'd0, 4'd2, 4'd5);
        start = 1'b1;
        @(negedge clk);               // after E2
        start = 1'b0;
        @(negedge clk);               // after E3
        @(negedge clk);               // after E4
        chk("restart.no_early_done", {31'd0, done}, 32'd0);
        @(negedge clk);               // after E5
        chk("restart.done", {31'd0, done}, 32'd1);
        chk("restart.year", {20'd0, year}, 32'hBD1);
        chk("restart.err",  {31'd0, err},  32'd0);

        // Back-to-back: start while done is high
        set_digits(4'd2, 4'd0, 4'd2, 4'd5);
        start = 1'b1;
        @(negedge clk);               // after E6 (new E0)
        start = 1'b0;
        chk("b2b.busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("b2b.done_mid", {31'd0, done}, 32'd0);
        end
        @(negedge clk);
        chk("b2b.done", {31'd0, done}, 32'd1);
        chk("b2b.year", {20'd0, year}, 32'h7E9);
        chk("b2b.err",  {31'd0, err},  32'd0);
        @(negedge clk);
        chk("b2b.done_once", {31'd0, done}, 32'd0);

        // Reset between E2 and E3 aborts with no done pulse
        set_digits(4'd3, 4'd0, 4'd2, 4'd5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);               // between E2 and E3
        rst = 1'b1;
        #1;
        chk("abort.busy", {31'd0, busy}, 32'd0);
        chk("abort.year", {20'd0, year}, 32'd0);
        chk("abort.err",  {31'd0, err},  32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort.no_done", {31'd0, done}, 32'd0);
            chk("abort.idle", {31'd0, busy}, 32'd0);
        end
        do_conv("post_abort", 4'd2, 4'd5, 4'd0, 4'd0,
                RC ? 12'h9C4 : 12'h9C4, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
